eth_rx_frame_ctrl: RTL and testbench

- Receive-side frame controller between the RMII byte receiver (data/valid/eop stream, clk50 domain) and a slotted packet buffer RAM.
- Writes each frame into a free ring slot and checks the FCS (CRC-32) and frame length.
- Commits good frames to a descriptor ring for the consumer; drops bad frames, and frames arriving with no free slot, and counts them.
- The consumer reads committed frames from RAM and releases slots in order.

---
 rtl/eth_rx_frame_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_eth_rx_frame_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_frame_ctrl.sv
// Receive-side frame controller: RMII byte stream -> slotted packet buffer RAM.
//
// Each incoming frame is written into the next free ring slot while its CRC-32
// and length are checked. Good frames are committed to an in-order descriptor
// ring. Bad frames, and frames that arrive when every slot is in use, are
// dropped and counted. The consumer releases slots oldest-first with rel.
//
// Ports:
//   clk50        50 MHz clock (sole clock)
//   rst_n        asynchronous active-low reset
//   in_data      received byte, valid when in_valid
//   in_valid     one-cycle strobe per byte (at most one per 4 clocks)
//   in_eop       one-cycle pulse after the last byte of a frame
//   buf_wr_en    RAM write strobe (registered)
//   buf_wr_addr  RAM address {slot, byte index} (registered)
//   buf_wr_data  RAM write data (registered)
//   rdy          at least one committed frame is pending
//   rdy_slot     slot of the oldest pending frame
//   rdy_len      length of the oldest pending frame, FCS excluded
//   rel          release the oldest pending slot
//   drop_full    frames dropped for lack of a free slot (saturating)
//   drop_bad     frames dropped for bad CRC or length (saturating)
module eth_rx_frame_ctrl #(
    parameter int unsigned SLOTS   = 4,
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1522,
    localparam int unsigned SW     = $clog2(SLOTS)
) (
    input  logic           clk50,
    input  logic           rst_n,
    input  logic [7:0]     in_data,
    input  logic           in_valid,
    input  logic           in_eop,
    output logic           buf_wr_en,
    output logic [SW+10:0] buf_wr_addr,
    output logic [7:0]     buf_wr_data,
    output logic           rdy,
    output logic [SW-1:0]  rdy_slot,
    output logic [10:0]    rdy_len,
    input  logic           rel,
    output logic [15:0]    drop_full,
    output logic [15:0]    drop_bad
);

    localparam logic [10:0] MinLen    = 11'(MIN_LEN);
    localparam logic [10:0] MaxLen    = 11'(MAX_LEN);
    localparam logic [SW:0] CountFull = (SW+1)'(SLOTS);
    localparam logic [31:0] CrcResid  = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        StIdle,
        StRecv,
        StCheck,
        StDiscard,
        StDiscardBad
    } state_e;

    state_e        state_q;
    logic [10:0]   byte_cnt_q;
    logic [31:0]   crc_q;
    logic [SW-1:0] wr_ptr_q;
    logic [SW-1:0] rd_ptr_q;
    logic [SW:0]   count_q;
    logic [10:0]   len_table_q [SLOTS];

    logic          frame_good;
    logic          commit;
    logic          do_rel;
    logic [10:0]   len_commit;
    logic [SW-1:0] wr_ptr_d;
    logic [SW-1:0] rd_ptr_d;
    logic [SW:0]   count_d;
    logic [10:0]   rdy_len_d;

    // Reflected CRC-32 (poly 0xEDB88320), one byte, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
        end
        return r;
    endfunction

    always_comb begin
        frame_good = (crc_q == CrcResid) && (byte_cnt_q >= MinLen) && (byte_cnt_q <= MaxLen);
        commit     = (state_q == StCheck) && frame_good;
        do_rel     = rel && (count_q != '0);
        len_commit = byte_cnt_q - 11'd4;
        wr_ptr_d   = commit ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = do_rel ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        case ({commit, do_rel})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A frame committed on this edge may itself become the oldest pending
        // one (ring was empty, or its only entry is being released); bypass
        // the table so rdy_len is correct on the same edge as rdy.
        if (commit && (rd_ptr_d == wr_ptr_q)) begin
            rdy_len_d = len_commit;
        end else begin
            rdy_len_d = len_table_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            byte_cnt_q  <= '0;
            crc_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                len_table_q[i] <= '0;
            end
            buf_wr_en   <= 1'b0;
            buf_wr_addr <= '0;
            buf_wr_data <= '0;
            rdy         <= 1'b0;
            rdy_slot    <= '0;
            rdy_len     <= '0;
            drop_full   <= '0;
            drop_bad    <= '0;
        end else begin
            buf_wr_en <= 1'b0;

            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (commit) begin
                len_table_q[wr_ptr_q] <= len_commit;
            end
            rdy      <= (count_d != '0);
            rdy_slot <= rd_ptr_d;
            rdy_len  <= rdy_len_d;

            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        if (count_q == CountFull) begin
                            state_q <= StDiscard;
                        end else begin
                            buf_wr_en   <= 1'b1;
                            buf_wr_addr <= {wr_ptr_q, 11'd0};
                            buf_wr_data <= in_data;
                            byte_cnt_q  <= 11'd1;
                            crc_q       <= crc_byte(32'hFFFFFFFF, in_data);
                            state_q     <= StRecv;
                        end
                    end
                end
                StRecv: begin
                    if (in_valid) begin
                        if (byte_cnt_q == MaxLen) begin
                            state_q <= StDiscardBad;
                        end else begin
                            buf_wr_en   <= 1'b1;
                            buf_wr_addr <= {wr_ptr_q, byte_cnt_q};
                            buf_wr_data <= in_data;
                            byte_cnt_q  <= byte_cnt_q + 11'd1;
                            crc_q       <= crc_byte(crc_q, in_data);
                        end
                    end else if (in_eop) begin
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    if (!frame_good && (drop_bad != 16'hFFFF)) begin
                        drop_bad <= drop_bad + 16'd1;
                    end
                    state_q <= StIdle;
                end
                StDiscard: begin
                    if (in_eop) begin
                        if (drop_full != 16'hFFFF) begin
                            drop_full <= drop_full + 16'd1;
                        end
                        state_q <= StIdle;
                    end
                end
                StDiscardBad: begin
                    if (in_eop) begin
                        if (drop_bad != 16'hFFFF) begin
                            drop_bad <= drop_bad + 16'd1;
                        end
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// Bench for eth_rx_frame_ctrl: expected RAM writes and descriptors are queued
// by the stimulus and popped by a monitor when the DUT writes or a slot is
// released; counters and rdy timing are checked directly.
module tb_eth_rx_frame_ctrl;

    localparam int SW      = 2;
    localparam int MAX_LEN = 1522;

    logic          clk50;
    logic          rst_n;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_eop;
    logic          buf_wr_en;
    logic [SW+10:0] buf_wr_addr;
    logic [7:0]    buf_wr_data;
    logic          rdy;
    logic [SW-1:0] rdy_slot;
    logic [10:0]   rdy_len;
    logic          rel;
    logic [15:0]   drop_full;
    logic [15:0]   drop_bad;

    eth_rx_frame_ctrl dut (
        .clk50       (clk50),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_eop      (in_eop),
        .buf_wr_en   (buf_wr_en),
        .buf_wr_addr (buf_wr_addr),
        .buf_wr_data (buf_wr_data),
        .rdy         (rdy),
        .rdy_slot    (rdy_slot),
        .rdy_len     (rdy_len),
        .rel         (rel),
        .drop_full   (drop_full),
        .drop_bad    (drop_bad)
    );

    initial clk50 = 1'b0;
    always #10 clk50 = ~clk50;

    typedef struct packed {
        logic [SW+10:0] addr;
        logic [7:0]     data;
    } wr_t;

    typedef struct packed {
        logic [SW-1:0] slot;
        logic [10:0]   len;
    } desc_t;

    wr_t        wq[$];
    desc_t      dq[$];
    logic [7:0] frm[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: samples mid-cycle, away from the rising edge.
    always @(negedge clk50) begin
        if (buf_wr_en === 1'b1) begin
            if (wq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                         buf_wr_addr, buf_wr_data);
            end else begin
                wr_t e;
                e = wq.pop_front();
                check("wr_addr", 32'(buf_wr_addr), 32'(e.addr));
                check("wr_data", 32'(buf_wr_data), 32'(e.data));
            end
        end
        if (rel === 1'b1 && rdy === 1'b1) begin
            if (dq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_desc: got slot %0d len %0d expected none",
                         rdy_slot, rdy_len);
            end else begin
                desc_t d;
                d = dq.pop_front();
                check("desc_slot", 32'(rdy_slot), 32'(d.slot));
                check("desc_len", 32'(rdy_len), 32'(d.len));
            end
        end
    end

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
        end
        return r;
    endfunction

    // Builds payload of len-4 bytes plus its FCS into frm.
    task automatic build_frame(input int len, input int seed, input bit corrupt);
        logic [31:0] crc;
        logic [31:0] fcs;
        logic [7:0]  b;
        frm.delete();
        crc = 32'hFFFFFFFF;
        for (int i = 0; i < len - 4; i++) begin
            b = 8'(seed * 37 + i * 11 + 5);
            frm.push_back(b);
            crc = crc_upd(crc, b);
        end
        fcs = ~crc;
        frm.push_back(fcs[7:0]);
        frm.push_back(fcs[15:8]);
        frm.push_back(fcs[23:16]);
        frm.push_back(fcs[31:24]);
        if (corrupt) frm[len-1] = frm[len-1] ^ 8'h01;
    endtask

    task automatic tick();
        @(posedge clk50);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick();
        in_data  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
    endtask

    // Returns with the DUT in its post-eop cycle; rel_chk pulses rel there.
    task automatic send_frame(input int len, input int seed, input bit corrupt,
                              input int slot, input bit exp_wr, input bit rel_chk);
        build_frame(len, seed, corrupt);
        for (int i = 0; i < len; i++) begin
            if (exp_wr && i < MAX_LEN) wq.push_back('{addr: {SW'(slot), 11'(i)}, data: frm[i]});
            send_byte(frm[i]);
        end
        tick();
        in_eop = 1'b1;
        tick();
        in_eop = 1'b0;
        if (rel_chk) begin
            rel = 1'b1;
            tick();
            rel = 1'b0;
        end
    endtask

    task automatic pulse_rel();
        tick();
        rel = 1'b1;
        tick();
        rel = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        in_data  = '0;
        in_valid = 1'b0;
        in_eop   = 1'b0;
        rel      = 1'b0;
        rst_n    = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk50);
        check("rst_wr_en", 32'(buf_wr_en), 0);
        check("rst_wr_addr", 32'(buf_wr_addr), 0);
        check("rst_wr_data", 32'(buf_wr_data), 0);
        check("rst_rdy", 32'(rdy), 0);
        check("rst_rdy_slot", 32'(rdy_slot), 0);
        check("rst_rdy_len", 32'(rdy_len), 0);
        check("rst_drop_full", 32'(drop_full), 0);
        check("rst_drop_bad", 32'(drop_bad), 0);

        // Good 64-byte frame: rdy on the second edge after the eop cycle.
        send_frame(64, 1, 0, 0, 1, 0);
        @(negedge clk50);
        check("t1_rdy_in_check", 32'(rdy), 0);
        tick();
        @(negedge clk50);
        check("t1_rdy", 32'(rdy), 1);
        check("t1_rdy_slot", 32'(rdy_slot), 0);
        check("t1_rdy_len", 32'(rdy_len), 60);
        check("t1_drop_bad", 32'(drop_bad), 0);

        // Bad FCS, then a good frame reusing slot 0.
        do_reset();
        send_frame(64, 2, 1, 0, 1, 0);
        tick();
        tick();
        @(negedge clk50);
        check("t2_rdy_bad", 32'(rdy), 0);
        check("t2_drop_bad", 32'(drop_bad), 1);
        send_frame(64, 3, 0, 0, 1, 0);
        tick();
        @(negedge clk50);
        check("t2_rdy", 32'(rdy), 1);
        check("t2_rdy_slot", 32'(rdy_slot), 0);
        check("t2_rdy_len", 32'(rdy_len), 60);
        dq.push_back('{slot: 2'd0, len: 11'd60});
        pulse_rel();
        check("t2_drop_bad_after", 32'(drop_bad), 1);

        // Fill all slots, fifth frame dropped, then drain.
        do_reset();
        for (int k = 0; k < 4; k++) send_frame(100, 10 + k, 0, k, 1, 0);
        tick();
        tick();
        @(negedge clk50);
        check("t3_rdy", 32'(rdy), 1);
        check("t3_rdy_slot", 32'(rdy_slot), 0);
        check("t3_rdy_len", 32'(rdy_len), 96);
        check("t3_drop_full0", 32'(drop_full), 0);
        send_frame(100, 20, 0, 0, 0, 0);
        tick();
        tick();
        @(negedge clk50);
        check("t3_drop_full", 32'(drop_full), 1);
        check("t3_drop_bad", 32'(drop_bad), 0);
        for (int k = 0; k < 4; k++) begin
            dq.push_back('{slot: SW'(k), len: 11'd96});
            pulse_rel();
        end
        tick();
        @(negedge clk50);
        check("t3_rdy_drained", 32'(rdy), 0);
        pulse_rel();
        tick();
        @(negedge clk50);
        check("t3_rel_empty_rdy", 32'(rdy), 0);
        check("t3_rel_empty_slot", 32'(rdy_slot), 0);

        // Length limits: short frame and oversize frame.
        do_reset();
        send_frame(63, 30, 0, 0, 1, 0);
        tick();
        tick();
        @(negedge clk50);
        check("t4_short_drop_bad", 32'(drop_bad), 1);
        check("t4_short_rdy", 32'(rdy), 0);
        send_frame(1600, 31, 0, 0, 1, 0);
        tick();
        tick();
        @(negedge clk50);
        check("t4_long_drop_bad", 32'(drop_bad), 2);
        check("t4_long_rdy", 32'(rdy), 0);
        check("t4_long_wq_empty", 32'(wq.size()), 0);

        // Commit and release on the same edge, then pointer wrap.
        do_reset();
        send_frame(64, 40, 0, 0, 1, 0);
        tick();
        @(negedge clk50);
        check("t5_a_rdy", 32'(rdy), 1);
        dq.push_back('{slot: 2'd0, len: 11'd60});
        send_frame(64, 41, 0, 1, 1, 1);
        @(negedge clk50);
        check("t5_b_rdy", 32'(rdy), 1);
        check("t5_b_slot", 32'(rdy_slot), 1);
        check("t5_b_len", 32'(rdy_len), 60);
        send_frame(70, 42, 0, 2, 1, 0);
        send_frame(80, 43, 0, 3, 1, 0);
        send_frame(90, 44, 0, 0, 1, 0);
        tick();
        @(negedge clk50);
        check("t5_drop_full", 32'(drop_full), 0);
        check("t5_slot_before", 32'(rdy_slot), 1);
        dq.push_back('{slot: 2'd1, len: 11'd60});
        dq.push_back('{slot: 2'd2, len: 11'd66});
        dq.push_back('{slot: 2'd3, len: 11'd76});
        dq.push_back('{slot: 2'd0, len: 11'd86});
        repeat (4) pulse_rel();
        tick();
        @(negedge clk50);
        check("t5_drained", 32'(rdy), 0);
        pulse_rel();
        tick();
        @(negedge clk50);
        check("t5_rel_empty_rdy", 32'(rdy), 0);
        check("t5_rel_empty_slot", 32'(rdy_slot), 1);

        // Asynchronous reset mid-frame.
        do_reset();
        send_frame(64, 50, 0, 0, 1, 0);
        tick();
        @(negedge clk50);
        check("t6_pre_rdy", 32'(rdy), 1);
        build_frame(64, 51, 0);
        for (int i = 0; i < 20; i++) begin
            wq.push_back('{addr: {2'd1, 11'(i)}, data: frm[i]});
            send_byte(frm[i]);
        end
        tick();
        rst_n = 1'b0;
        #1;
        check("t6_rst_wr_en", 32'(buf_wr_en), 0);
        check("t6_rst_wr_addr", 32'(buf_wr_addr), 0);
        check("t6_rst_wr_data", 32'(buf_wr_data), 0);
        check("t6_rst_rdy", 32'(rdy), 0);
        check("t6_rst_rdy_slot", 32'(rdy_slot), 0);
        check("t6_rst_rdy_len", 32'(rdy_len), 0);
        check("t6_rst_drop_bad", 32'(drop_bad), 0);
        tick();
        rst_n = 1'b1;
        for (int i = 20; i < 64; i++) begin
            wq.push_back('{addr: {2'd0, 11'(i - 20)}, data: frm[i]});
            send_byte(frm[i]);
        end
        tick();
        in_eop = 1'b1;
        tick();
        in_eop = 1'b0;
        tick();
        tick();
        @(negedge clk50);
        check("t6_drop_bad", 32'(drop_bad), 1);
        check("t6_rdy", 32'(rdy), 0);

        repeat (4) tick();
        check("end_wq_empty", 32'(wq.size()), 0);
        check("end_dq_empty", 32'(dq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
